// File: rtl/axi_sram_slave.sv
// AXI3 slave bridging one read or write burst at a time onto a single-port
// synchronous SRAM with one-cycle read latency.
module axi_sram_slave #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {IDLE, R_FETCH, R_DATA, W_DATA, W_RESP} state_t;

  state_t            state_q, state_d;
  logic              lastRd_q, lastRd_d;
  logic [3:0]        id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_q, beat_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;

  logic              rdGnt, wrGnt;
  logic [ADDR_W-1:0] lenMask, addrNext;

  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, wid, araddr[1:0], araddr[31:ADDR_W+2],
                       awaddr[1:0], awaddr[31:ADDR_W+2]};

  // Reserved burst type and WRAP with a non power-of-two length both fall back to INCR.
  function automatic logic badBurst(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11) ||
           ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  endfunction

  assign rdGnt = arvalid && (!awvalid || !lastRd_q);
  assign wrGnt = awvalid && (!arvalid || lastRd_q);

  assign lenMask = ADDR_W'(len_q);

  always_comb begin
    case (burst_q)
      2'b00:   addrNext = addr_q;
      2'b10:   addrNext = (addr_q & ~lenMask) | ((addr_q + 1'b1) & lenMask);
      default: addrNext = addr_q + 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    lastRd_d  = lastRd_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    err_d     = err_q;
    arready   = 1'b0;
    awready   = 1'b0;
    rvalid    = 1'b0;
    rdata     = 32'h0;
    rid       = 4'h0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bid       = 4'h0;
    bresp     = 2'b00;
    ram_en    = 1'b0;
    ram_we    = 4'h0;
    ram_addr  = addr_q;
    ram_wdata = 32'h0;

    case (state_q)
      IDLE: begin
        if (rdGnt) begin
          arready  = 1'b1;
          state_d  = R_FETCH;
          lastRd_d = 1'b1;
          id_d     = arid;
          addr_d   = araddr[ADDR_W+1:2];
          len_d    = arlen;
          beat_d   = 8'd0;
          burst_d  = badBurst(arburst, arlen) ? 2'b01 : arburst;
          err_d    = (arsize != 3'b010) || badBurst(arburst, arlen);
        end else if (wrGnt) begin
          awready  = 1'b1;
          state_d  = W_DATA;
          lastRd_d = 1'b0;
          id_d     = awid;
          addr_d   = awaddr[ADDR_W+1:2];
          len_d    = awlen;
          beat_d   = 8'd0;
          burst_d  = badBurst(awburst, awlen) ? 2'b01 : awburst;
          err_d    = (awsize != 3'b010) || badBurst(awburst, awlen);
        end
      end
      R_FETCH: begin
        ram_en  = 1'b1;
        state_d = R_DATA;
      end
      // SRAM stays enabled on the same address so its output holds until the beat is taken.
      R_DATA: begin
        ram_en = 1'b1;
        rvalid = 1'b1;
        rdata  = ram_rdata;
        rid    = id_q;
        rresp  = err_q ? 2'b10 : 2'b00;
        rlast  = (beat_q == len_q);
        if (rready) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            addr_d  = addrNext;
            beat_d  = beat_q + 1'b1;
            state_d = R_FETCH;
          end
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en    = 1'b1;
          ram_we    = wstrb;
          ram_wdata = wdata;
          addr_d    = addrNext;
          beat_d    = beat_q + 1'b1;
          if (beat_q == len_q) begin
            err_d   = err_q | ~wlast;
            state_d = W_RESP;
          end else begin
            err_d   = err_q | wlast;
          end
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = err_q ? 2'b10 : 2'b00;
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rstn) begin
      arready = 1'b0;
      awready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      lastRd_q <= 1'b0;
      id_q     <= 4'h0;
      addr_q   <= '0;
      len_q    <= 8'd0;
      beat_q   <= 8'd0;
      burst_q  <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lastRd_q <= lastRd_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      burst_q  <= burst_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed bursts push expected beats,
// grants and responses; a negedge monitor pops and compares them.
module tb_axi_sram_slave;
  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 400;

  logic              clk = 1'b0;
  logic              rstn;
  logic [3:0]        arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [3:0]        awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [3:0]        wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // SRAM model: any word never written reads back as its own word address.
  logic [31:0] mem     [0:(1<<ADDR_W)-1];
  bit          written [0:(1<<ADDR_W)-1];
  logic [31:0] memCur;
  always @(posedge clk) begin
    if (ram_en) begin
      memCur = written[ram_addr] ? mem[ram_addr] : 32'(ram_addr);
      if (ram_we == 4'h0) begin
        ram_rdata <= memCur;
      end else begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) memCur[8*b +: 8] = ram_wdata[8*b +: 8];
        mem[ram_addr]     <= memCur;
        written[ram_addr] <= 1'b1;
      end
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } rBeat_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bResp_t;

  rBeat_t rExp[$];
  bResp_t bExp[$];
  bit     gExp[$];

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int lastBeatCycle = 0;
  bit midBurst = 1'b0;
  bit holdB = 1'b0;

  logic [31:0] expData [16];
  logic [31:0] wData   [16];
  logic [3:0]  wStrb   [16];
  logic        wLast   [16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got missing or unexpected event, required none", name);
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: every handshake the DUT offers is matched against the scoreboard.
  always @(negedge clk) begin
    rBeat_t e;
    bResp_t br;
    bit g;
    if (!rstn) begin
      midBurst = 1'b0;
    end else begin
      if (arvalid && arready) begin
        if (gExp.size() == 0) reportFail("unexpectedArGrant");
        else begin g = gExp.pop_front(); checkOutput("grantIsWrite", 32'(0), 32'(g)); end
      end
      if (awvalid && awready) begin
        if (gExp.size() == 0) reportFail("unexpectedAwGrant");
        else begin g = gExp.pop_front(); checkOutput("grantIsWrite", 32'(1), 32'(g)); end
      end
      if (rvalid && rready) begin
        if (rExp.size() == 0) reportFail("unexpectedRBeat");
        else begin
          e = rExp.pop_front();
          checkOutput("rdata", rdata, e.data);
          checkOutput("rid", 32'(rid), 32'(e.id));
          checkOutput("rresp", 32'(rresp), 32'(e.resp));
          checkOutput("rlast", 32'(rlast), 32'(e.last));
          if (midBurst) checkOutput("beatGap", 32'(cycle - lastBeatCycle), 32'(2));
          lastBeatCycle = cycle;
          midBurst = !rlast;
        end
      end
      if (bvalid && bready) begin
        if (bExp.size() == 0) reportFail("unexpectedBResp");
        else begin
          br = bExp.pop_front();
          checkOutput("bid", 32'(bid), 32'(br.id));
          checkOutput("bresp", 32'(bresp), 32'(br.resp));
        end
      end
    end
  end

  task automatic pushRead(input logic [3:0] id, input logic [1:0] resp, input int len);
    rBeat_t e;
    for (int i = 0; i <= len; i++) begin
      e.data = expData[i];
      e.id   = id;
      e.resp = resp;
      e.last = (i == len);
      rExp.push_back(e);
    end
  endtask

  task automatic pushWrite(input logic [3:0] id, input logic [1:0] resp);
    bResp_t br;
    br.id   = id;
    br.resp = resp;
    bExp.push_back(br);
  endtask

  task automatic waitHandshake(input int which);
    int n = 0;
    logic rdy;
    @(negedge clk);
    rdy = (which == 0) ? arready : (which == 1) ? awready : wready;
    while (!rdy && n < TIMEOUT) begin
      @(negedge clk);
      n++;
      rdy = (which == 0) ? arready : (which == 1) ? awready : wready;
    end
    if (!rdy) reportFail("handshakeTimeout");
    @(posedge clk);
    #1;
  endtask

  task automatic issueRead(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    waitHandshake(0);
    arvalid = 1'b0;
  endtask

  task automatic issueWrite(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    waitHandshake(1);
    awvalid = 1'b0;
  endtask

  task automatic sendWData(input int len);
    for (int i = 0; i <= len; i++) begin
      wdata = wData[i]; wstrb = wStrb[i]; wlast = wLast[i]; wvalid = 1'b1;
      waitHandshake(2);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((rExp.size() != 0 || bExp.size() != 0) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) reportFail("drainTimeout");
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit isWrite, input logic [3:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    if (isWrite) begin
      issueWrite(id, addr, len, size, burst);
      sendWData(int'(len));
      if (holdB) begin
        bready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("bvalidHeld", 32'(bvalid), 32'(1));
          checkOutput("bidHeld", 32'(bid), 32'(id));
        end
        bready = 1'b1;
      end
    end else begin
      issueRead(id, addr, len, size, burst);
    end
    waitDrain();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    arid = 4'h0; araddr = 32'h0; arlen = 8'd0; arsize = 3'b010; arburst = 2'b01;
    arlock = 2'b00; arcache = 4'h0; arprot = 3'b000; arvalid = 1'b1;
    awid = 4'h0; awaddr = 32'h0; awlen = 8'd0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
    wid = 4'h0; wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b1;
    rready = 1'b1; bready = 1'b1;

    // Reset: everything quiet even with valids raised.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstArready", 32'(arready), 32'(0));
    checkOutput("rstAwready", 32'(awready), 32'(0));
    checkOutput("rstWready", 32'(wready), 32'(0));
    checkOutput("rstRvalid", 32'(rvalid), 32'(0));
    checkOutput("rstBvalid", 32'(bvalid), 32'(0));
    checkOutput("rstRamEn", 32'(ram_en), 32'(0));
    checkOutput("rstRamWe", 32'(ram_we), 32'(0));
    checkOutput("rstIds", 32'({rid, bid, rresp, bresp}), 32'(0));
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous AR/AW twice: read first, then write, then the second read.
    gExp.push_back(1'b0); gExp.push_back(1'b1); gExp.push_back(1'b0);
    expData[0] = 32'd16; expData[1] = 32'd17;
    pushRead(4'h1, 2'b00, 1);
    pushWrite(4'h2, 2'b00);
    expData[0] = 32'h1234_5678;
    pushRead(4'h1, 2'b00, 0);
    wData[0] = 32'h1234_5678; wStrb[0] = 4'hF; wLast[0] = 1'b1;
    fork
      begin
        issueRead(4'h1, 32'h40, 8'd1, 3'b010, 2'b01);
        issueRead(4'h1, 32'h400, 8'd0, 3'b010, 2'b01);
      end
      begin
        issueWrite(4'h2, 32'h400, 8'd0, 3'b010, 2'b01);
        sendWData(0);
      end
    join
    waitDrain();
    checkOutput("idleRamEn", 32'(ram_en), 32'(0));

    // INCR read of 16 beats from word 8.
    gExp.push_back(1'b0);
    for (int i = 0; i < 16; i++) expData[i] = 32'(8 + i);
    pushRead(4'h3, 2'b00, 15);
    applyStimulus(1'b0, 4'h3, 32'h20, 8'd15, 3'b010, 2'b01);

    // WRAP read from word 14 with a 16-word window: 14,15,0..13.
    gExp.push_back(1'b0);
    expData[0] = 32'd14; expData[1] = 32'd15;
    for (int i = 2; i < 16; i++) expData[i] = 32'(i - 2);
    pushRead(4'h4, 2'b00, 15);
    applyStimulus(1'b0, 4'h4, 32'h38, 8'd15, 3'b010, 2'b10);

    // Four-beat write with a partial strobe on the third beat, B held off for a while.
    gExp.push_back(1'b1);
    wData[0] = 32'hAAAA_AAAA; wData[1] = 32'hBBBB_BBBB; wData[2] = 32'hCCCC_CCCC; wData[3] = 32'hDDDD_DDDD;
    wStrb[0] = 4'hF; wStrb[1] = 4'hF; wStrb[2] = 4'h3; wStrb[3] = 4'hF;
    wLast[0] = 1'b0; wLast[1] = 1'b0; wLast[2] = 1'b0; wLast[3] = 1'b1;
    pushWrite(4'h6, 2'b00);
    holdB = 1'b1;
    applyStimulus(1'b1, 4'h6, 32'h100, 8'd3, 3'b010, 2'b01);
    holdB = 1'b0;
    gExp.push_back(1'b0);
    expData[0] = 32'hAAAA_AAAA; expData[1] = 32'hBBBB_BBBB;
    expData[2] = 32'h0000_CCCC; expData[3] = 32'hDDDD_DDDD;
    pushRead(4'hA, 2'b00, 3);
    applyStimulus(1'b0, 4'hA, 32'h100, 8'd3, 3'b010, 2'b01);

    // Illegal size on a read: SLVERR on every beat, data still delivered.
    gExp.push_back(1'b0);
    for (int i = 0; i < 4; i++) expData[i] = 32'(i);
    pushRead(4'h7, 2'b10, 3);
    applyStimulus(1'b0, 4'h7, 32'h0, 8'd3, 3'b001, 2'b01);

    // Early wlast on a 4-beat write: SLVERR after all beats.
    gExp.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin wData[i] = 32'h5500_0000 + 32'(i); wStrb[i] = 4'hF; wLast[i] = 1'b0; end
    wLast[0] = 1'b1;
    pushWrite(4'h8, 2'b10);
    applyStimulus(1'b1, 4'h8, 32'h300, 8'd3, 3'b010, 2'b01);

    // Reset mid-write: beats 3-4 dropped, no response, later read works.
    gExp.push_back(1'b1);
    issueWrite(4'h5, 32'h200, 8'd3, 3'b010, 2'b01);
    wdata = 32'h1111_1111; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    waitHandshake(2);
    wdata = 32'h2222_2222;
    waitHandshake(2);
    wdata = 32'h3333_3333;
    #1;
    checkOutput("beat3RamEn", 32'(ram_en), 32'(1));
    #1 rstn = 1'b0;
    #1;
    checkOutput("abortWready", 32'(wready), 32'(0));
    checkOutput("abortRamEn", 32'(ram_en), 32'(0));
    checkOutput("abortRamWe", 32'(ram_we), 32'(0));
    checkOutput("abortBvalid", 32'(bvalid), 32'(0));
    @(posedge clk);
    #1 wvalid = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    gExp.push_back(1'b0);
    expData[0] = 32'h1111_1111; expData[1] = 32'h2222_2222;
    expData[2] = 32'h0000_0082; expData[3] = 32'h0000_0083;
    pushRead(4'h9, 2'b00, 3);
    applyStimulus(1'b0, 4'h9, 32'h200, 8'd3, 3'b010, 2'b01);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("rQueueLeft", 32'(rExp.size()), 32'(0));
    checkOutput("bQueueLeft", 32'(bExp.size()), 32'(0));
    checkOutput("gQueueLeft", 32'(gExp.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, giving the SRAM word-address width (64 KiB).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have AXI read-address inputs arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arvalid (1), and output arready (1); arlock, arcache and arprot are accepted and ignored.
REQ-005 SHALL have AXI read-data outputs rid[3:0], rdata[31:0], rresp[1:0], rlast (1), rvalid (1), and input rready (1).
REQ-006 SHALL have AXI write-address inputs awid[3:0], awaddr[31:0], awlen[7:0], awsize[2:0], awburst[1:0], awvalid (1), and output awready (1).
REQ-007 SHALL have AXI write-data inputs wid[3:0] (ignored), wdata[31:0], wstrb[3:0], wlast (1), wvalid (1), and output wready (1).
REQ-008 SHALL have AXI write-response outputs bid[3:0], bresp[1:0], bvalid (1), and input bready (1).
REQ-009 SHALL have SRAM outputs ram_en (1), ram_we[3:0], ram_addr[ADDR_W-1:0] (word address), ram_wdata[31:0], and input ram_rdata[31:0], which is valid one cycle after a cycle with ram_en=1 and ram_we=0.

Function
REQ-010 SHALL serve one transaction at a time with states IDLE, R_FETCH, R_DATA, W_DATA and W_RESP.
REQ-011 SHALL, in IDLE, grant read or write: if only one valid is high, that side wins; if both are high, the side not granted last wins; the first grant after reset goes to read.
REQ-012 SHALL drive arready/awready high only in IDLE and only for the granted side; on handshake it SHALL latch id, word address araddr[ADDR_W+1:2], len, burst and an error flag.
REQ-013 SHALL set the error flag when size!=3'b010, burst==2'b11, or burst==WRAP (2'b10) with len not in {1,3,7,15}; the transfer still runs, with the address following INCR rules for burst 2'b11 or an illegal WRAP.
REQ-014 SHALL compute the next address as: FIXED (2'b00) unchanged; INCR (2'b01) +1 modulo 2^ADDR_W; WRAP (addr & ~len) | ((addr+1) & len), using len as the wrap mask.
REQ-015 SHALL go from read handshake to R_FETCH; R_FETCH drives ram_en=1, ram_we=0, ram_addr=current address for one cycle, then enters R_DATA.
REQ-016 SHALL, in R_DATA, hold ram_en=1 and ram_addr constant, drive rvalid=1, rdata=ram_rdata, rid=latched id, rresp=2'b10 if error else 2'b00, and rlast=1 on the beat where the beat count equals len.
REQ-017 SHALL, on rvalid&rready: if it is the last beat, go to IDLE; otherwise advance the address and beat count and return to R_FETCH (2 cycles per beat minimum).
REQ-018 SHALL go from write handshake to W_DATA with wready=1; on each wvalid&wready it SHALL drive, combinationally in the same cycle, ram_en=1, ram_we=wstrb, ram_addr=current address, ram_wdata=wdata, then advance the address and beat count.
REQ-019 SHALL treat a write beat as final when the beat count equals len, regardless of wlast; wlast=1 on a non-final beat or wlast=0 on the final beat SHALL set the error flag; W_DATA then goes to W_RESP.
REQ-020 SHALL, in W_RESP, drive bvalid=1, bid=latched id, bresp=2'b10 if error else 2'b00, and hold these until bready; on bvalid&bready it SHALL go to IDLE.
REQ-021 SHALL keep ram_en=0 and ram_we=0 whenever no SRAM access is specified above; the beat counter SHALL be 8 bits wide.

Reset
REQ-022 SHALL, while rstn=0, force state to IDLE, clear the last-grant register, and drive all valid/ready outputs, ram_en and ram_we to 0 and rid, bid, rresp, bresp and the counters to 0.
REQ-023 SHALL, on reset assertion mid-burst, abort immediately with no further SRAM write and no response, and after release accept a new request in IDLE.

Verification
REQ-024 SHALL be verified by: pre-fill words 0..15 = index; AR araddr=0x20, arlen=15, arburst=INCR, rready=1 -> rdata 8..23 (aliasing past 15 to the fill), rlast only on beat 16, rresp=0, 2 cycles/beat.
REQ-025 SHALL be verified by: WRAP read araddr=0x38, arlen=15 -> word addresses 14,15,0,1..13.
REQ-026 SHALL be verified by: write awaddr=0x100, awlen=3, wdata A..D, wstrb 4'hF except beat 2 = 4'h3 -> bresp=0, readback shows only the low 16 bits of word 0x42 updated.
REQ-027 SHALL be verified by: arvalid and awvalid rising in the same IDLE cycle twice in a row -> read granted first, write second; rid/bid echo the respective ids 4'h1 and 4'h2.
REQ-028 SHALL be verified by: arsize=3'b001 read, and a write with wlast on beat 1 of 4 -> rresp=2'b10 on every beat; bresp=2'b10 after all 4 beats.
REQ-029 SHALL be verified by: rstn pulsed low during beat 2 of a 4-beat write -> outputs 0 asynchronously, beats 3-4 not written, and a subsequent read succeeds.
